// File: rtl/mac_dot_if.sv
// mac_dot_if: operand-in / result-out bus of the mac_dot engine.
//
// Handshake rule, identical on both channels: a transfer happens on a rising
// clock edge where valid and ready are both high. The producer holds valid and
// its payload steady until that edge. Ready may depend combinationally on
// valid. It may fall in the same cycle that downstream backpressure appears.
//
// Signals
//   in_valid/in_ready/in_last/dataa/datab : operand channel (master -> engine)
//   out_valid/out_ready/result/out_count/out_ovf : result channel (engine -> master)
// Modports
//   master : operand source / result sink
//   slave  : the engine
interface mac_dot_if #(
  parameter int N       = 8,
  parameter int ACC_W   = 2*N+8,
  parameter int MAX_LEN = 256
);
  localparam int CNT_W = $clog2(MAX_LEN+1);

  logic             in_valid;
  logic             in_ready;
  logic             in_last;
  logic [N-1:0]     dataa;
  logic [N-1:0]     datab;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] result;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  modport master (
    output in_valid, in_last, dataa, datab, out_ready,
    input  in_ready, out_valid, result, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_last, dataa, datab, out_ready,
    output in_ready, out_valid, result, out_count, out_ovf
  );
endinterface

// File: rtl/mac_dot.sv
// mac_dot: pipelined signed multiply-accumulate that produces one dot product
// per framed vector of operand pairs.
//
// Pipeline: S1 registers operands + last, S2 registers the signed product,
// S3 accumulates and loads the output register on the last term. A vector ends
// on in_last or on its MAX_LEN-th term. The accumulator restarts from zero in
// the same cycle that a result loads, so vectors can follow with no gap.
//
// Ports
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   clear : synchronous flush of pipeline, accumulator and output register
//   bus   : mac_dot_if slave modport (operand and result channels)
module mac_dot #(
  parameter int N       = 8,
  parameter int ACC_W   = 2*N+8,
  parameter int MAX_LEN = 256,
  parameter int SAT     = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  mac_dot_if.slave    bus
);
  localparam int CNT_W = $clog2(MAX_LEN+1);
  localparam int P_W   = 2*N;

  logic                    en;
  logic                    in_ready_w;
  logic                    accept;
  logic                    beat_last;
  logic signed [ACC_W:0]   sum;
  logic                    sum_ovf;
  logic [ACC_W-1:0]        sum_fix;

  logic [CNT_W-1:0]        in_cnt_q, in_cnt_d;
  logic                    s1_valid_q, s1_valid_d;
  logic                    s1_last_q, s1_last_d;
  logic signed [N-1:0]     s1_a_q, s1_a_d;
  logic signed [N-1:0]     s1_b_q, s1_b_d;
  logic                    s2_valid_q, s2_valid_d;
  logic                    s2_last_q, s2_last_d;
  logic signed [P_W-1:0]   s2_prod_q, s2_prod_d;
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic [CNT_W-1:0]        term_q, term_d;
  logic                    sticky_q, sticky_d;
  logic                    out_valid_q, out_valid_d;
  logic [ACC_W-1:0]        result_q, result_d;
  logic [CNT_W-1:0]        out_count_q, out_count_d;
  logic                    out_ovf_q, out_ovf_d;

  always_comb begin
    en         = !out_valid_q || bus.out_ready;
    // rst_n is included so the engine never claims to accept during reset.
    in_ready_w = en && !clear && rst_n;
    accept     = bus.in_valid && in_ready_w;
    // The MAX_LEN-th term of a vector acts as an implicit last.
    beat_last  = bus.in_last || (in_cnt_q == CNT_W'(MAX_LEN-1));

    // Sum in ACC_W+1 bits; overflow when the top two bits disagree.
    sum     = $signed({acc_q[ACC_W-1], acc_q})
            + $signed({{(ACC_W+1-P_W){s2_prod_q[P_W-1]}}, s2_prod_q});
    sum_ovf = sum[ACC_W] ^ sum[ACC_W-1];
    if (sum_ovf && (SAT != 0))
      sum_fix = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    else
      sum_fix = sum[ACC_W-1:0];

    in_cnt_d    = in_cnt_q;
    s1_valid_d  = s1_valid_q;
    s1_last_d   = s1_last_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s2_valid_d  = s2_valid_q;
    s2_last_d   = s2_last_q;
    s2_prod_d   = s2_prod_q;
    acc_d       = acc_q;
    term_d      = term_q;
    sticky_d    = sticky_q;
    // When en is low this reduces to a hold, since out_valid is high then.
    out_valid_d = out_valid_q && !bus.out_ready;
    result_d    = result_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;

    if (accept)
      in_cnt_d = beat_last ? '0 : in_cnt_q + CNT_W'(1);

    if (en) begin
      s1_valid_d = accept;
      if (accept) begin
        s1_a_d    = $signed(bus.dataa);
        s1_b_d    = $signed(bus.datab);
        s1_last_d = beat_last;
      end
      s2_valid_d = s1_valid_q;
      s2_last_d  = s1_last_q;
      s2_prod_d  = P_W'(s1_a_q) * P_W'(s1_b_q);

      if (s2_valid_q) begin
        if (s2_last_q) begin
          result_d    = sum_fix;
          out_count_d = term_q + CNT_W'(1);
          out_ovf_d   = sticky_q | sum_ovf;
          out_valid_d = 1'b1;
          acc_d       = '0;
          term_d      = '0;
          sticky_d    = 1'b0;
        end else begin
          acc_d    = sum_fix;
          term_d   = term_q + CNT_W'(1);
          sticky_d = sticky_q | sum_ovf;
        end
      end
    end

    if (clear) begin
      in_cnt_d    = '0;
      s1_valid_d  = 1'b0;
      s2_valid_d  = 1'b0;
      acc_d       = '0;
      term_d      = '0;
      sticky_d    = 1'b0;
      out_valid_d = 1'b0;
      result_d    = '0;
      out_count_d = '0;
      out_ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_cnt_q    <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s2_valid_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_prod_q   <= '0;
      acc_q       <= '0;
      term_q      <= '0;
      sticky_q    <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      in_cnt_q    <= in_cnt_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s2_valid_q  <= s2_valid_d;
      s2_last_q   <= s2_last_d;
      s2_prod_q   <= s2_prod_d;
      acc_q       <= acc_d;
      term_q      <= term_d;
      sticky_q    <= sticky_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.out_count = out_count_q;
  assign bus.out_ovf   = out_ovf_q;
endmodule

// File: doc/mac_dot.md
# mac_dot

Parametrised, pipelined signed multiply-accumulate engine that computes dot products of streamed operand pairs. It replaces the free-running accumulator with framed vectors: each vector ends on a `last` marker or on a length limit. The accumulator clears itself between vectors with no bubble. It adds valid/ready handshakes, optional saturation with an overflow flag, and a term count. It sits between operand-fetch logic and the filter/convolution result path.

## Interface
- `N`, 8, operand width in bits (signed two's complement)
- `ACC_W`, 2*N+8, accumulator/result width; must be >= 2*N
- `MAX_LEN`, 256, maximum terms per vector; >= 1
- `SAT`, 1, 1 = saturate accumulator at ACC_W bounds, 0 = wrap
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `clear`  in  1  synchronous flush of the pipeline, accumulator and output
- `in_valid`  in  1  operand pair valid
- `in_ready`  out  1  engine accepts the pair this cycle
- `in_last`  in  1  pair is the final term of the vector
- `dataa`, `datab`  in  N each  signed operands
- `out_valid`  out  1  result register holds a completed vector
- `out_ready`  in  1  downstream consumes the result
- `result`  out  ACC_W  signed dot product
- `out_count`  out  $clog2(MAX_LEN+1)  number of terms in the vector
- `out_ovf`  out  1  overflow occurred at some point in the vector

## Operation
- Three registered stages:
  - S1: operands plus last flag.
  - S2: signed product, 2*N bits, sign-extended to ACC_W.
  - S3: accumulate, then the output register.
- Each stage carries a valid bit. Bubbles do not touch the accumulator or the count.
- Global enable `en = !out_valid || out_ready`. All stages advance only when `en` is high.
- `in_ready = en && !clear`. A beat is accepted when `in_valid && in_ready`.
- The term counter increments per accepted beat. A beat is the vector end if `in_last` is high or if it is the MAX_LEN-th term; the latter is an implicit last.
- At S3 with a valid non-last product: `acc <= acc + prod`.
- At S3 with a valid last product:
  - `result <= acc + prod` (saturated or wrapped), `out_count` <= terms, `out_ovf` <= sticky flag, `out_valid` <= 1.
  - `acc`, count and sticky flag reset to 0 in the same cycle, so the next vector's first product accumulates from 0.
- Sum arithmetic:
  - Computed in ACC_W+1 bits. Overflow means the sum falls outside [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - SAT=1: clamp to the nearest bound.
  - SAT=0: keep the low ACC_W bits.
  - Either mode sets the per-vector sticky flag. Later terms accumulate from the clamped or wrapped value.
- `out_valid` falls after a cycle with `out_ready` high, unless a new result loads in that cycle. `result`, `out_count` and `out_ovf` remain stable while `out_valid && !out_ready`.
- `clear` has priority over all activity except reset. It zeroes stage valids, acc, count, sticky, `out_valid`, `result`, `out_count` and `out_ovf`. The beat presented in that cycle is not accepted.

## Timing
- Reset values: `out_valid`=0, `result`=0, `out_count`=0, `out_ovf`=0. Internal state is 0. `in_ready` is 0 while `rst_n` is low and 1 in the first cycle after release.
- Latency: last beat accepted at the end of cycle t gives `out_valid` high in cycle t+3.
- Throughput: one beat per cycle with no backpressure. Back-to-back vectors produce no gap; a 1-term vector can follow immediately.
- Backpressure: `out_valid && !out_ready` drops `in_ready` in the same cycle (combinational) and freezes all stages.
- Reset asserted mid-vector discards all partial state immediately.

## Test plan
- Reset: hold `rst_n` low with random inputs -> all outputs 0 and `in_ready`=0. After release, `in_ready`=1 and the first vector starts from acc 0.
- Single vector (N=8, ACC_W=24): pairs (3,4), (-2,5), (127,127), (-128,-128) with last on the 4th -> `result`=32515, `out_count`=4, `out_ovf`=0, `out_valid` 3 cycles after the last acceptance.
- Back-to-back vectors, `out_ready`=1: (2,3) then (1,1)+last, immediately followed by (-4,4)+last -> results 7 then -16 in consecutive-beat spacing with no carry-over.
- Backpressure: hold `out_ready`=0 for 5 cycles while the result (value 10) is valid -> `in_ready`=0 and `result` stable. After release, the held next vector completes correctly.
- Saturation (N=8, ACC_W=16): three (-128,-128) terms plus last:
  - SAT=1 -> 32767, `out_ovf`=1.
  - SAT=0 -> -16384, `out_ovf`=1.
  - Next vector (1,1)+last -> 1, `out_ovf`=0.
- Length limit, clear and reset (MAX_LEN=16): 16 (1,1) beats with no last -> `result`=16, `out_count`=16, and the 17th beat starts a new vector. `clear` mid-vector -> the next vector (5,5)+last gives 25. `rst_n` pulse mid-vector -> all outputs 0.
